// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin shared write port onto an SR flag bank; in clk, reset (sync, active-low), req_valid/req_cmd/req_idx; out req_ready, flags, flags_bar, grant_id, busy, plus err when SR_FLAG_ILLEGAL_DET_EN is defined
module sr_flag_arbiter #(
    parameter int NREQ   = 4,
    parameter int NFLAGS = 8,
    parameter int IDX_W  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [2*NREQ-1:0]     req_cmd,
    input  logic [IDX_W*NREQ-1:0] req_idx,
    output logic [NREQ-1:0]       req_ready,
    output logic [NFLAGS-1:0]     flags,
    output logic [NFLAGS-1:0]     flags_bar,
    output logic [IDX_W-1:0]      grant_id,
`ifdef SR_FLAG_ILLEGAL_DET_EN
    output logic                  err,
`endif
    output logic                  busy
);
    typedef enum logic {ARB, APPLY} state_t;
`ifdef SR_FLAG_ILLEGAL_DET_EN
    localparam bit TOGGLE = 1'b0;
`else
    localparam bit TOGGLE = 1'b1;
`endif
    state_t            state;
    logic [IDX_W-1:0]  rr_ptr, win, lidx;
    logic [1:0]        lcmd;
    logic [NFLAGS-1:0] flags_nxt;
    always_comb begin
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--) win = req_valid[i] ? IDX_W'(i) : win;
        for (int i = NREQ - 1; i >= 0; i--) win = (req_valid[i] && IDX_W'(i) >= rr_ptr) ? IDX_W'(i) : win;
    end
    assign req_ready = (state == ARB && |req_valid) ? {{(NREQ-1){1'b0}}, 1'b1} << win : '0;
    assign flags_bar = ~flags;
    always_comb begin
        flags_nxt = flags;
        for (int i = 0; i < NFLAGS; i++)
            if (IDX_W'(i) == lidx)
                flags_nxt[i] = lcmd == 2'b01 ? 1'b0 :
                               lcmd == 2'b10 ? 1'b1 :
                               (lcmd == 2'b11 && TOGGLE) ? ~flags[i] : flags[i];
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ARB;
            rr_ptr   <= '0;
            grant_id <= '0;
            lcmd     <= '0;
            lidx     <= '0;
            flags    <= '0;
            busy     <= 1'b0;
`ifdef SR_FLAG_ILLEGAL_DET_EN
            err      <= 1'b0;
`endif
        end else if (state == ARB) begin
            if (|req_valid) begin
                lcmd     <= req_cmd[2*int'(win) +: 2];
                lidx     <= req_idx[IDX_W*int'(win) +: IDX_W];
                grant_id <= win;
                busy     <= 1'b1;
                state    <= APPLY;
            end
        end else begin
            flags  <= flags_nxt;
            rr_ptr <= grant_id == IDX_W'(NREQ - 1) ? '0 : grant_id + 1'b1;
            busy   <= 1'b0;
            state  <= ARB;
`ifdef SR_FLAG_ILLEGAL_DET_EN
            err    <= err | lcmd == 2'b11 | int'(lidx) >= NFLAGS;
`endif
        end
    end
endmodule
